protocol_rr_sched: RTL and testbench

//   Round-robin scheduler that shares one protocol_fsm channel among NREQ requesters.

---
 rtl/protocol_pkg.sv | 14 +
 rtl/protocol_rr_pick.sv | 28 ++
 rtl/protocol_rr_sched.sv | 132 +++++++++++++
 tb/tb_protocol_rr_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// Shared types and defaults for the protocol channel scheduler.
package protocol_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RELEASE
  } sched_state_t;

  localparam int HOLD_DEF    = 2;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/protocol_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping at NREQ.
module protocol_rr_pick
  import protocol_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [IW-1:0]   idx_o,
  output logic [NREQ-1:0] oh_o
);

  // Scan NREQ positions starting just after the pointer; the pointer itself is checked last.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
        vld_o = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % NREQ);
      end
    end
    oh_o = vld_o ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/protocol_rr_sched.sv
// Round-robin scheduler sharing one protocol_fsm channel among NREQ requesters.
module protocol_rr_sched
  import protocol_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int HOLD    = HOLD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic [NREQ-1:0]         err_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    busy_o,
  output logic                    ch_in,
  input  logic                    ch_dout
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t    state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0]   owner_q, owner_d, ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            ch_in_q, ch_in_d, busy_q, busy_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;

  protocol_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx),
    .oh_o  (pick_oh)
  );

  // Next-state and registered-output values; done/err default low so they pulse one cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    ch_in_d = ch_in_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          ch_in_d = 1'b1;
          hold_d  = HW'(HOLD - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        // ch_dout is deliberately ignored while the start line is held.
        if (hold_q == '0) begin
          ch_in_d = 1'b0;
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_WAIT: begin
        // Completion is checked first so it beats a coincident timeout.
        if (ch_dout) begin
          done_d  = gnt_q;
          state_d = S_RELEASE;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d   = gnt_q;
          state_d = S_RELEASE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Extra idle cycle keeps ch_in low long enough for the channel to settle back to idle.
        gnt_d   = '0;
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      hold_q  <= '0;
      wait_q  <= '0;
      ch_in_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      ch_in_q <= ch_in_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
  assign ch_in   = ch_in_q;

endmodule

// File: tb/tb_protocol_rr_sched.sv
// Directed bench for protocol_rr_sched (NREQ=4, HOLD=2, TIMEOUT=16).
module tb_protocol_rr_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_i;
  logic [3:0] gnt_o, done_o, err_o;
  logic [1:0] owner_o;
  logic       busy_o, ch_in, ch_dout;

  int tests = 0;
  int fails = 0;

  protocol_rr_sched #(.NREQ(4), .HOLD(2), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .owner_o (owner_o),
    .busy_o  (busy_o),
    .ch_in   (ch_in),
    .ch_dout (ch_dout)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after the grant edge. dcyc = WAIT cycle in which ch_dout is high (0 = never).
  // Returns just after the edge that issues the following grant.
  task automatic run_txn(input string tag, input logic [3:0] eg, input int eo, input int dcyc);
    chk({tag, ".gnt"},   gnt_o, eg);
    chk({tag, ".owner"}, owner_o, eo);
    chk({tag, ".ch1"},   ch_in, 1);
    chk({tag, ".busy"},  busy_o, 1);
    step();
    chk({tag, ".ch2"},   ch_in, 1);
    step();
    chk({tag, ".ch0"},   ch_in, 0);
    chk({tag, ".gntw"},  gnt_o, eg);
    for (int k = 1; k <= 16; k++) begin
      ch_dout = (k == dcyc);
      step();
      if (k == dcyc || k == 16) break;
    end
    ch_dout = 1'b0;
    chk({tag, ".done"},  done_o, (dcyc != 0) ? eg : 4'b0000);
    chk({tag, ".err"},   err_o,  (dcyc == 0) ? eg : 4'b0000);
    chk({tag, ".gntr"},  gnt_o, eg);
    step();
    chk({tag, ".gnt0"},  gnt_o, 0);
    chk({tag, ".pulse0"}, {done_o, err_o}, 0);
    chk({tag, ".idle"},  busy_o, 0);
    step();
  endtask

  initial begin
    rstn    = 1'b0;
    req_i   = 4'b1111;
    ch_dout = 1'b0;

    // 1: reset held two cycles with all requests active
    step();
    step();
    chk("rst.gnt", gnt_o, 0);
    chk("rst.ch", ch_in, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.owner", owner_o, 0);
    chk("rst.pulse", {done_o, err_o}, 0);
    rstn = 1'b1;
    step();

    // 2: round-robin rotation with completion in WAIT cycle 3
    run_txn("rr0", 4'b0001, 0, 3);
    run_txn("rr1", 4'b0010, 1, 3);
    run_txn("rr2", 4'b0100, 2, 3);
    run_txn("rr3", 4'b1000, 3, 3);
    run_txn("rr4", 4'b0001, 0, 3);

    // 3: no completion -> timeout, then next requester
    run_txn("tmo", 4'b0010, 1, 0);
    // 4: completion coincident with timeout -> done only
    run_txn("tie", 4'b0100, 2, 16);

    // 5: reset in the middle of WAIT
    chk("r5.gnt", gnt_o, 4'b1000);
    step();
    step();
    step();
    rstn = 1'b0;
    step();
    chk("r5.gnt0", gnt_o, 0);
    chk("r5.ch0", ch_in, 0);
    chk("r5.busy0", busy_o, 0);
    chk("r5.owner0", owner_o, 0);
    rstn = 1'b1;
    step();
    chk("r5.prio", gnt_o, 4'b0001);

    // 6: owner drops request, another request arrives mid-transaction
    req_i = 4'b0000;
    step();
    chk("r6.ch", ch_in, 1);
    chk("r6.gnt", gnt_o, 4'b0001);
    req_i = 4'b0100;
    step();
    step();
    step();
    ch_dout = 1'b1;
    step();
    ch_dout = 1'b0;
    chk("r6.done", done_o, 4'b0001);
    step();
    chk("r6.gnt0", gnt_o, 0);
    step();
    chk("r6.next", gnt_o, 4'b0100);
    chk("r6.owner", owner_o, 2);
    chk("r6.chn", ch_in, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
